adder_rr_scheduler: RTL and testbench



---
 rtl/adder_rr_scheduler.sv | 79 +++++++
 tb/tb_adder_rr_scheduler.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/adder_rr_scheduler.sv
// adder_rr_scheduler: round-robin arbiter sharing one external 4-bit adder among NREQ requesters
module adder_rr_scheduler #(
    parameter int NREQ = 4,
    localparam int IDW = $clog2(NREQ)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NREQ-1:0]   req_valid,
    output logic [NREQ-1:0]   req_ready,
    input  logic [NREQ*4-1:0] req_a,
    input  logic [NREQ*4-1:0] req_b,
    output logic [3:0]        adder_a,
    output logic [3:0]        adder_b,
    input  logic [4:0]        adder_sum,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [4:0]        rsp_sum,
    output logic [IDW-1:0]    rsp_id,
    output logic              busy
);
    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;
    state_t state, state_n;
    logic [IDW-1:0] ptr, gnt, id_q;
    logic [NREQ-1:0] rot;
    logic [IDW:0] off, gsum;
    logic any, accept;
    logic [3:0] op_a, op_b;
    // grant: first valid requester at or after ptr, wrapping mod NREQ
    always_comb begin
        rot = NREQ'({req_valid, req_valid} >> ptr);
        any = |rot;
        off = '0;
        for (int k = NREQ - 1; k >= 0; k--) if (rot[k]) off = (IDW+1)'(k);
        gsum = {1'b0, ptr} + off;
        gnt = (gsum >= (IDW+1)'(NREQ)) ? IDW'(gsum - (IDW+1)'(NREQ)) : IDW'(gsum);
    end
    // next state and handshake outputs; ready is forced low while reset is held
    always_comb begin
        accept = (state == IDLE) && any;
        req_ready = (accept && !rst) ? (NREQ'(1) << gnt) : '0;
        state_n = accept ? EXEC :
                  (state == EXEC) ? RESP :
                  (state == RESP && rsp_ready) ? IDLE : state;
    end
    // state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else state <= state_n;
    end
    // operand capture, pointer advance and response register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr <= '0;
            op_a <= '0;
            op_b <= '0;
            id_q <= '0;
            rsp_valid <= 1'b0;
            rsp_sum <= '0;
            rsp_id <= '0;
        end else begin
            if (accept) begin
                op_a <= req_a[4*gnt +: 4];
                op_b <= req_b[4*gnt +: 4];
                id_q <= gnt;
                ptr <= (gnt == IDW'(NREQ - 1)) ? '0 : gnt + 1'b1;
            end
            if (state == EXEC) begin
                rsp_sum <= adder_sum;
                rsp_id <= id_q;
                rsp_valid <= 1'b1;
            end else if (state == RESP && rsp_ready) begin
                rsp_valid <= 1'b0;
            end
        end
    end
    assign adder_a = op_a;
    assign adder_b = op_b;
    assign busy = (state != IDLE);
endmodule

// File: tb/tb_adder_rr_scheduler.sv
// tb_adder_rr_scheduler: directed checks of the round-robin adder scheduler (NREQ=4 and NREQ=2)
module tb_adder_rr_scheduler;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic [3:0]  req_valid, req_ready;
    logic [15:0] req_a, req_b;
    logic [3:0]  adder_a, adder_b;
    logic [4:0]  adder_sum, rsp_sum;
    logic        rsp_valid, rsp_ready, busy;
    logic [1:0]  rsp_id;

    logic [1:0]  v2, rdy2;
    logic [7:0]  a2, b2;
    logic [3:0]  aa2, ab2;
    logic [4:0]  as2, rs2;
    logic        rv2, rr2, busy2;
    logic [0:0]  rid2;

    int n_cmp = 0;
    int n_err = 0;

    assign adder_sum = 5'(adder_a) + 5'(adder_b);
    assign as2 = 5'(aa2) + 5'(ab2);

    adder_rr_scheduler #(.NREQ(4)) d4 (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
        .req_a(req_a), .req_b(req_b), .adder_a(adder_a), .adder_b(adder_b),
        .adder_sum(adder_sum), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_sum(rsp_sum), .rsp_id(rsp_id), .busy(busy)
    );

    adder_rr_scheduler #(.NREQ(2)) d2 (
        .clk(clk), .rst(rst), .req_valid(v2), .req_ready(rdy2),
        .req_a(a2), .req_b(b2), .adder_a(aa2), .adder_b(ab2),
        .adder_sum(as2), .rsp_valid(rv2), .rsp_ready(rr2),
        .rsp_sum(rs2), .rsp_id(rid2), .busy(busy2)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // one full operation on the 4-requester instance, starting in IDLE with rsp_ready=1
    task automatic op4(input int id, input int sum);
        chk("op4 ready", 32'(req_ready), 32'(1) << id);
        chk("op4 idle busy", 32'(busy), 0);
        tick();
        chk("op4 exec busy", 32'(busy), 1);
        chk("op4 exec ready", 32'(req_ready), 0);
        chk("op4 exec rsp_valid", 32'(rsp_valid), 0);
        tick();
        chk("op4 rsp_valid", 32'(rsp_valid), 1);
        chk("op4 rsp_id", 32'(rsp_id), 32'(id));
        chk("op4 rsp_sum", 32'(rsp_sum), 32'(sum));
        chk("op4 resp ready", 32'(req_ready), 0);
        tick();
        chk("op4 done rsp_valid", 32'(rsp_valid), 0);
        chk("op4 done busy", 32'(busy), 0);
    endtask

    task automatic op2(input int id, input int sum);
        chk("op2 ready", 32'(rdy2), 32'(1) << id);
        tick();
        chk("op2 exec busy", 32'(busy2), 1);
        tick();
        chk("op2 rsp_valid", 32'(rv2), 1);
        chk("op2 rsp_id", 32'(rid2), 32'(id));
        chk("op2 rsp_sum", 32'(rs2), 32'(sum));
        tick();
        chk("op2 done rsp_valid", 32'(rv2), 0);
    endtask

    initial begin
        rsp_ready = 1'b1;
        req_valid = 4'b0000;
        req_a = 16'h321F;
        req_b = 16'h4321;
        v2 = 2'b00;
        a2 = 8'h53;
        b2 = 8'h64;
        rr2 = 1'b1;
        repeat (2) tick();
        chk("rst rsp_valid", 32'(rsp_valid), 0);
        chk("rst rsp_sum", 32'(rsp_sum), 0);
        chk("rst rsp_id", 32'(rsp_id), 0);
        chk("rst busy", 32'(busy), 0);
        chk("rst req_ready", 32'(req_ready), 0);
        chk("rst adder_a", 32'(adder_a), 0);
        chk("rst adder_b", 32'(adder_b), 0);
        rst = 1'b0;
        tick();

        req_valid = 4'b0001;
        #1;
        chk("t1 ready", 32'(req_ready), 32'h1);
        chk("t1 idle busy", 32'(busy), 0);
        tick();
        chk("t1 exec busy", 32'(busy), 1);
        chk("t1 exec ready", 32'(req_ready), 0);
        chk("t1 adder_a", 32'(adder_a), 32'hF);
        chk("t1 adder_b", 32'(adder_b), 32'h1);
        chk("t1 exec rsp_valid", 32'(rsp_valid), 0);
        req_valid = 4'b0000;
        tick();
        chk("t1 rsp_valid", 32'(rsp_valid), 1);
        chk("t1 rsp_sum", 32'(rsp_sum), 32'h10);
        chk("t1 rsp_id", 32'(rsp_id), 0);
        chk("t1 resp busy", 32'(busy), 1);
        tick();
        chk("t1 done rsp_valid", 32'(rsp_valid), 0);
        chk("t1 done busy", 32'(busy), 0);

        rst = 1'b1;
        #1;
        rst = 1'b0;
        #1;
        req_a = 16'h3210;
        req_valid = 4'b1111;
        #1;
        for (int k = 0; k < 6; k++) op4(k % 4, 2 * (k % 4) + 1);

        rsp_ready = 1'b0;
        chk("t3 ready", 32'(req_ready), 32'h4);
        tick();
        tick();
        chk("t3 rsp_valid", 32'(rsp_valid), 1);
        chk("t3 rsp_id", 32'(rsp_id), 2);
        chk("t3 rsp_sum", 32'(rsp_sum), 5);
        for (int k = 0; k < 5; k++) begin
            tick();
            chk("t3 hold rsp_valid", 32'(rsp_valid), 1);
            chk("t3 hold rsp_id", 32'(rsp_id), 2);
            chk("t3 hold rsp_sum", 32'(rsp_sum), 5);
            chk("t3 hold ready", 32'(req_ready), 0);
            chk("t3 hold busy", 32'(busy), 1);
        end
        rsp_ready = 1'b1;
        tick();
        chk("t3 release rsp_valid", 32'(rsp_valid), 0);
        chk("t3 next ready", 32'(req_ready), 32'h8);
        op4(3, 7);

        req_valid = 4'b0010;
        req_a = 16'h7210;
        req_b = 16'h9320;
        #1;
        op4(1, 3);
        req_valid = 4'b1001;
        #1;
        op4(3, 16);
        op4(0, 0);

        req_valid = 4'b0001;
        req_a = 16'h721F;
        req_b = 16'h9321;
        #1;
        chk("t5 ready", 32'(req_ready), 32'h1);
        tick();
        chk("t5 exec busy", 32'(busy), 1);
        req_valid = 4'b0110;
        #2;
        rst = 1'b1;
        #1;
        chk("t5 rst rsp_valid", 32'(rsp_valid), 0);
        chk("t5 rst ready", 32'(req_ready), 0);
        chk("t5 rst busy", 32'(busy), 0);
        chk("t5 rst adder_a", 32'(adder_a), 0);
        tick();
        chk("t5 no rsp", 32'(rsp_valid), 0);
        rst = 1'b0;
        #1;
        chk("t5 post rsp_valid", 32'(rsp_valid), 0);
        chk("t5 post ready", 32'(req_ready), 32'h2);
        op4(1, 3);

        v2 = 2'b11;
        #1;
        for (int k = 0; k < 4; k++) op2(k % 2, (k % 2 == 1) ? 11 : 7);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
